// File: rtl/isp_demosaic_seq.sv
// isp_demosaic_seq: turns a valid/ready raw pixel stream into continuous href/vsync/de frame timing for isp_demosaic
//   pclk, rst (async, active-high)
//   enable                  : allows a new frame to start from IDLE
//   s_valid/s_ready/s_data/s_sof : source pixel stream (s_ready combinational from state)
//   dm_href/dm_vsync/dm_de/dm_raw : registered timing and pixel to the demosaic
//   busy                    : not in IDLE
//   frame_done/underrun/err_sof : registered one-cycle status pulses
module isp_demosaic_seq #(
    parameter int BITS        = 8,
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 960,
    parameter int HBLANK      = 16,
    parameter int VS_CYCLES   = 4,
    parameter int FLUSH_LINES = 3
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            enable,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_data,
    input  logic            s_sof,
    output logic            dm_href,
    output logic            dm_vsync,
    output logic            dm_de,
    output logic [BITS-1:0] dm_raw,
    output logic            busy,
    output logic            frame_done,
    output logic            underrun,
    output logic            err_sof
);
    localparam int BMAX = HBLANK > VS_CYCLES ? HBLANK : VS_CYCLES;
    localparam int PW   = $clog2(WIDTH + 1) > 0 ? $clog2(WIDTH + 1) : 1;
    localparam int BW   = $clog2(BMAX + 1) > 0 ? $clog2(BMAX + 1) : 1;
    localparam int LW   = $clog2(HEIGHT + 1) > 0 ? $clog2(HEIGHT + 1) : 1;
    localparam int FW   = $clog2(FLUSH_LINES + 1) > 0 ? $clog2(FLUSH_LINES + 1) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(WIDTH - 1);
    localparam logic [BW-1:0] HB_LAST  = BW'(HBLANK - 1);
    localparam logic [BW-1:0] VS_LAST  = BW'(VS_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, HBLANK_S, LINE, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            first_q, first_d;
    logic            href_q, href_d, vsync_q, vsync_d, de_q, de_d;
    logic [BITS-1:0] raw_q, raw_d;
    logic            done_q, done_d, under_q, under_d, errsof_q, errsof_d;
    logic            in_line, hs;

    assign in_line = state_q == LINE;
    assign hs      = in_line & s_valid;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        blank_cnt_d = blank_cnt_q;
        line_cnt_d  = line_cnt_q;
        flush_cnt_d = flush_cnt_q;
        first_d     = first_q & ~hs;
        s_ready     = 1'b0;
        case (state_q)
            IDLE: begin
                // stray non-SOF pixels are drained; the SOF pixel is held for the first line
                s_ready = s_valid & ~s_sof;
                if (s_valid & s_sof & enable) begin
                    state_d     = VSYNC;
                    blank_cnt_d = '0;
                    line_cnt_d  = '0;
                    flush_cnt_d = '0;
                    first_d     = 1'b1;
                end
            end
            VSYNC: begin
                if (blank_cnt_q == VS_LAST) begin
                    state_d     = HBLANK_S;
                    blank_cnt_d = '0;
                end else blank_cnt_d = blank_cnt_q + 1'b1;
            end
            HBLANK_S: begin
                if (blank_cnt_q == HB_LAST) begin
                    pix_cnt_d = '0;
                    state_d   = line_cnt_q < LW'(HEIGHT) ? LINE :
                                flush_cnt_q < FW'(FLUSH_LINES) ? FLUSH : DONE;
                end else blank_cnt_d = blank_cnt_q + 1'b1;
            end
            LINE: begin
                s_ready = 1'b1;
                if (pix_cnt_q == PIX_LAST) begin
                    state_d     = HBLANK_S;
                    blank_cnt_d = '0;
                    line_cnt_d  = line_cnt_q + 1'b1;
                end else pix_cnt_d = pix_cnt_q + 1'b1;
            end
            FLUSH: begin
                if (pix_cnt_q == PIX_LAST) begin
                    state_d     = HBLANK_S;
                    blank_cnt_d = '0;
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end else pix_cnt_d = pix_cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // dm_raw holds the last accepted pixel on a missed slot; the blank before each
    // line forces it to 0 so a line that starts with a miss shows 0
    always_comb begin
        href_d   = in_line | (state_q == FLUSH);
        vsync_d  = state_q == VSYNC;
        de_d     = hs;
        raw_d    = in_line ? (s_valid ? s_data : raw_q) : '0;
        under_d  = in_line & ~s_valid;
        errsof_d = hs & s_sof & ~first_q;
        done_d   = state_q == DONE;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            blank_cnt_q <= '0;
            line_cnt_q  <= '0;
            flush_cnt_q <= '0;
            first_q     <= 1'b0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            raw_q       <= '0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
            errsof_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            line_cnt_q  <= line_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            first_q     <= first_d;
            href_q      <= href_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            raw_q       <= raw_d;
            done_q      <= done_d;
            under_q     <= under_d;
            errsof_q    <= errsof_d;
        end
    end

    assign dm_href    = href_q;
    assign dm_vsync   = vsync_q;
    assign dm_de      = de_q;
    assign dm_raw     = raw_q;
    assign frame_done = done_q;
    assign underrun   = under_q;
    assign err_sof    = errsof_q;
    assign busy       = state_q != IDLE;
endmodule
